// File: rtl/pipelined_decode_sequencer.sv
// pipelined_decode_sequencer
//   Registered opcode decoder at the ID/EX boundary. An instruction accepted
//   through InValid/InReady produces a control bundle one cycle later.
//   FP double loads/stores (0x35/0x3d) are replayed as DBL_BEATS word beats
//   while fetch is held off.
//
// Ports
//   clk, rst_n        rising-edge clock, synchronous active-low reset
//   InValid/InReady   instruction handshake (InReady is combinational)
//   OpCode, fmt, ft   instruction fields to decode
//   Stall             downstream hold: every register keeps its value
//   Flush             drops pending output and any beat sequence
//   OutValid          CtrlOut/BeatIdx/LastBeat/IllegalOp are meaningful
//   CtrlOut           {ALUop, 17 control bits}
//   BeatIdx, LastBeat beat position within a multi-beat instruction
//   IllegalOp         accepted opcode was not recognised
module pipelined_decode_sequencer #(
    parameter int unsigned ALUOP_W   = 4,
    parameter int unsigned FP_EN     = 1,
    parameter int unsigned DBL_BEATS = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  InValid,
    output logic                  InReady,
    input  logic [5:0]            OpCode,
    input  logic [4:0]            fmt,
    input  logic [4:0]            ft,
    input  logic                  Stall,
    input  logic                  Flush,
    output logic                  OutValid,
    output logic [17+ALUOP_W-1:0] CtrlOut,
    output logic [2:0]            BeatIdx,
    output logic                  LastBeat,
    output logic                  IllegalOp
);

    localparam logic [0:0] S_SINGLE = 1'b0;
    localparam logic [0:0] S_MULTI  = 1'b1;

    localparam int unsigned B_REGDST  = 0;
    localparam int unsigned B_REGWR   = 1;
    localparam int unsigned B_MEM2REG = 2;
    localparam int unsigned B_JUMP    = 3;
    localparam int unsigned B_JAL     = 4;
    localparam int unsigned B_MEMRD   = 5;
    localparam int unsigned B_MEMWR   = 6;
    localparam int unsigned B_BEQ     = 7;
    localparam int unsigned B_BNE     = 8;
    localparam int unsigned B_ALUSRC  = 9;
    localparam int unsigned B_FLOAT   = 10;
    localparam int unsigned B_SIGNED  = 11;
    localparam int unsigned B_DOUBLE  = 12;
    localparam int unsigned B_BYTE    = 13;
    localparam int unsigned B_BFPF    = 14;
    localparam int unsigned B_BFPT    = 15;
    localparam int unsigned B_FPLS    = 16;

    localparam logic [2:0] LAST_IDX = 3'(DBL_BEATS - 1);

    logic [0:0]            r_state;
    logic [2:0]            r_cnt;
    logic                  r_valid;
    logic [17+ALUOP_W-1:0] r_ctrl;
    logic [2:0]            r_beat;
    logic                  r_last;
    logic                  r_illegal;

    logic [16:0]           w_bits;
    logic [3:0]            w_alu;
    logic                  w_illegal;
    logic [17+ALUOP_W-1:0] w_ctrl;
    logic                  w_fp_en;
    logic                  w_multi;
    logic                  w_accept;

    assign w_fp_en  = (FP_EN != 0);
    assign w_multi  = w_fp_en && (DBL_BEATS > 1) && ((OpCode == 6'h35) || (OpCode == 6'h3d));
    assign InReady  = rst_n && (r_state == S_SINGLE) && !Stall && !Flush;
    assign w_accept = InValid && InReady;

    always_comb begin
        w_bits    = '0;
        w_alu     = 4'h0;
        w_illegal = 1'b0;
        case (OpCode)
            6'h12, 6'h22: begin
                w_bits[B_REGWR]   = 1'b1;
                w_bits[B_MEM2REG] = 1'b1;
                w_bits[B_MEMRD]   = 1'b1;
                w_bits[B_ALUSRC]  = 1'b1;
                w_bits[B_SIGNED]  = 1'b1;
                w_bits[B_BYTE]    = (OpCode == 6'h22);
                w_alu             = 4'h4;
            end
            6'h0f: begin
                w_bits[B_REGWR]  = 1'b1;
                w_bits[B_ALUSRC] = 1'b1;
                w_bits[B_SIGNED] = 1'b1;
                w_alu            = 4'hb;
            end
            6'h28, 6'h2b: begin
                w_bits[B_MEMWR]  = 1'b1;
                w_bits[B_ALUSRC] = 1'b1;
                w_bits[B_SIGNED] = 1'b1;
                w_bits[B_BYTE]   = (OpCode == 6'h28);
                w_alu            = 4'h4;
            end
            6'h03: begin
                w_bits[B_REGDST] = 1'b1;
                w_bits[B_REGWR]  = 1'b1;
                w_alu            = 4'h2;
            end
            6'h09, 6'h0c, 6'h0e: begin
                w_bits[B_REGWR]  = 1'b1;
                w_bits[B_ALUSRC] = 1'b1;
                w_alu = (OpCode == 6'h09) ? 4'h4 : (OpCode == 6'h0c) ? 4'h5 : 4'h3;
            end
            6'h05, 6'h04: begin
                w_bits[B_BEQ]    = (OpCode == 6'h05);
                w_bits[B_BNE]    = (OpCode == 6'h04);
                w_bits[B_SIGNED] = 1'b1;
                w_alu            = 4'h7;
            end
            6'h07: begin
                w_bits[B_REGWR] = 1'b1;
                w_bits[B_JAL]   = 1'b1;
                w_alu           = 4'ha;
            end
            6'h02: begin
                w_bits[B_JUMP] = 1'b1;
            end
            6'h11: begin
                if (!w_fp_en) begin
                    w_illegal = 1'b1;
                end else if (fmt == 5'h10 || fmt == 5'h11) begin
                    w_bits[B_FLOAT]  = 1'b1;
                    w_bits[B_REGDST] = 1'b1;
                    w_bits[B_DOUBLE] = (fmt == 5'h11);
                    w_alu            = 4'h2;
                end else if (fmt == 5'h08) begin
                    w_bits[B_SIGNED] = 1'b1;
                    w_bits[B_BFPT]   = (ft != 5'h00);
                    w_bits[B_BFPF]   = (ft == 5'h00);
                    w_alu            = 4'h7;
                end else begin
                    w_illegal = 1'b1;
                end
            end
            6'h31, 6'h35: begin
                if (w_fp_en) begin
                    w_bits[B_FLOAT]   = 1'b1;
                    w_bits[B_REGWR]   = 1'b1;
                    w_bits[B_MEM2REG] = 1'b1;
                    w_bits[B_MEMRD]   = 1'b1;
                    w_bits[B_ALUSRC]  = 1'b1;
                    w_bits[B_SIGNED]  = 1'b1;
                    w_bits[B_FPLS]    = 1'b1;
                    w_bits[B_DOUBLE]  = (OpCode == 6'h35);
                    w_alu             = 4'h4;
                end else begin
                    w_illegal = 1'b1;
                end
            end
            6'h39, 6'h3d: begin
                if (w_fp_en) begin
                    w_bits[B_MEMWR]  = 1'b1;
                    w_bits[B_ALUSRC] = 1'b1;
                    w_bits[B_SIGNED] = 1'b1;
                    w_bits[B_FPLS]   = 1'b1;
                    w_bits[B_DOUBLE] = (OpCode == 6'h3d);
                    w_alu            = 4'h4;
                end else begin
                    w_illegal = 1'b1;
                end
            end
            default: w_illegal = 1'b1;
        endcase
    end

    always_comb begin
        w_ctrl             = '0;
        w_ctrl[16:0]       = w_bits;
        w_ctrl[17 +: 4]    = w_alu;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_SINGLE;
            r_cnt     <= '0;
            r_valid   <= 1'b0;
            r_ctrl    <= '0;
            r_beat    <= '0;
            r_last    <= 1'b0;
            r_illegal <= 1'b0;
        end else if (Flush) begin
            r_valid <= 1'b0;
            r_state <= S_SINGLE;
            r_cnt   <= '0;
            r_ctrl  <= '0;
        end else if (!Stall) begin
            if (r_state == S_SINGLE) begin
                if (w_accept) begin
                    r_valid   <= 1'b1;
                    r_ctrl    <= w_ctrl;
                    r_illegal <= w_illegal;
                    r_beat    <= '0;
                    if (w_multi) begin
                        r_last  <= 1'b0;
                        r_cnt   <= 3'd1;
                        r_state <= S_MULTI;
                    end else begin
                        r_last <= 1'b1;
                    end
                end else begin
                    r_valid <= 1'b0;
                end
            end else begin
                // CtrlOut and IllegalOp are held from beat 0; only position advances
                r_valid <= 1'b1;
                r_beat  <= r_cnt;
                if (r_cnt == LAST_IDX) begin
                    r_last  <= 1'b1;
                    r_state <= S_SINGLE;
                    r_cnt   <= '0;
                end else begin
                    r_last <= 1'b0;
                    r_cnt  <= r_cnt + 3'd1;
                end
            end
        end
    end

    assign OutValid  = r_valid;
    assign CtrlOut   = r_ctrl;
    assign BeatIdx   = r_beat;
    assign LastBeat  = r_last;
    assign IllegalOp = r_illegal;

endmodule

// File: tb/tb_pipelined_decode_sequencer.sv
// tb_pipelined_decode_sequencer
//   Directed checks of pipelined_decode_sequencer. Instance dut has the FP
//   subset enabled with two-beat doubles; instance dut0 shares its inputs
//   with the FP subset disabled. Expected bundles are hand-computed.
module tb_pipelined_decode_sequencer;

    logic        clk;
    logic        rst_n;
    logic        InValid;
    logic [5:0]  OpCode;
    logic [4:0]  fmt;
    logic [4:0]  ft;
    logic        Stall;
    logic        Flush;

    logic        InReady,  OutValid,  LastBeat,  IllegalOp;
    logic [20:0] CtrlOut;
    logic [2:0]  BeatIdx;
    logic        InReady0, OutValid0, LastBeat0, IllegalOp0;
    logic [20:0] CtrlOut0;
    logic [2:0]  BeatIdx0;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    pipelined_decode_sequencer #(.ALUOP_W(4), .FP_EN(1), .DBL_BEATS(2)) dut (
        .clk(clk), .rst_n(rst_n), .InValid(InValid), .InReady(InReady),
        .OpCode(OpCode), .fmt(fmt), .ft(ft), .Stall(Stall), .Flush(Flush),
        .OutValid(OutValid), .CtrlOut(CtrlOut), .BeatIdx(BeatIdx),
        .LastBeat(LastBeat), .IllegalOp(IllegalOp)
    );

    pipelined_decode_sequencer #(.ALUOP_W(4), .FP_EN(0), .DBL_BEATS(2)) dut0 (
        .clk(clk), .rst_n(rst_n), .InValid(InValid), .InReady(InReady0),
        .OpCode(OpCode), .fmt(fmt), .ft(ft), .Stall(Stall), .Flush(Flush),
        .OutValid(OutValid0), .CtrlOut(CtrlOut0), .BeatIdx(BeatIdx0),
        .LastBeat(LastBeat0), .IllegalOp(IllegalOp0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_out(input string tag, input logic v, input logic [20:0] c,
                           input logic [2:0] b, input logic l, input logic i);
        chk({tag, ".valid"},   64'(OutValid),  64'(v));
        chk({tag, ".ctrl"},    64'(CtrlOut),   64'(c));
        chk({tag, ".beat"},    64'(BeatIdx),   64'(b));
        chk({tag, ".last"},    64'(LastBeat),  64'(l));
        chk({tag, ".illegal"}, 64'(IllegalOp), 64'(i));
    endtask

    task automatic exp_out0(input string tag, input logic v, input logic [20:0] c,
                            input logic [2:0] b, input logic l, input logic i);
        chk({tag, ".valid"},   64'(OutValid0),  64'(v));
        chk({tag, ".ctrl"},    64'(CtrlOut0),   64'(c));
        chk({tag, ".beat"},    64'(BeatIdx0),   64'(b));
        chk({tag, ".last"},    64'(LastBeat0),  64'(l));
        chk({tag, ".illegal"}, 64'(IllegalOp0), 64'(i));
    endtask

    initial begin
        rst_n = 1'b0; InValid = 1'b0; OpCode = 6'h00; fmt = 5'h00; ft = 5'h00;
        Stall = 1'b0; Flush = 1'b0;
        tick();
        tick();
        exp_out("reset", 1'b0, 21'h0, 3'd0, 1'b0, 1'b0);
        chk("reset_inready", 64'(InReady), 64'd0);

        // single-beat lw, then three back-to-back single ops
        rst_n = 1'b1; InValid = 1'b1; OpCode = 6'h12; #1;
        chk("lw_inready", 64'(InReady), 64'd1);
        tick();
        exp_out("lw", 1'b1, 21'h080A26, 3'd0, 1'b1, 1'b0);
        OpCode = 6'h03; #1;
        chk("rtype_inready", 64'(InReady), 64'd1);
        tick();
        exp_out("rtype", 1'b1, 21'h040003, 3'd0, 1'b1, 1'b0);
        OpCode = 6'h09; #1;
        chk("addi_inready", 64'(InReady), 64'd1);
        tick();
        exp_out("addi", 1'b1, 21'h080202, 3'd0, 1'b1, 1'b0);
        OpCode = 6'h2b; #1;
        chk("sw_inready", 64'(InReady), 64'd1);
        tick();
        exp_out("sw", 1'b1, 21'h080A40, 3'd0, 1'b1, 1'b0);

        // two-beat FP double load; a waiting lw must not be taken during beat 1
        OpCode = 6'h35;
        tick();
        exp_out("ldd_b0", 1'b1, 21'h091E26, 3'd0, 1'b0, 1'b0);
        OpCode = 6'h12; #1;
        chk("ldd_inready_low", 64'(InReady), 64'd0);
        tick();
        exp_out("ldd_b1", 1'b1, 21'h091E26, 3'd1, 1'b1, 1'b0);
        chk("ldd_inready_back", 64'(InReady), 64'd1);
        tick();
        exp_out("lw_after_ldd", 1'b1, 21'h080A26, 3'd0, 1'b1, 1'b0);

        // double store stalled for three cycles on beat 0
        OpCode = 6'h3d;
        tick();
        exp_out("sdd_b0", 1'b1, 21'h091A40, 3'd0, 1'b0, 1'b0);
        InValid = 1'b0; Stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            exp_out("sdd_stall", 1'b1, 21'h091A40, 3'd0, 1'b0, 1'b0);
            chk("sdd_stall_inready", 64'(InReady), 64'd0);
        end
        Stall = 1'b0;
        tick();
        exp_out("sdd_b1", 1'b1, 21'h091A40, 3'd1, 1'b1, 1'b0);
        tick();
        chk("idle_valid", 64'(OutValid), 64'd0);

        // flush during the multi-beat sequence
        InValid = 1'b1; OpCode = 6'h35;
        tick();
        exp_out("flush_b0", 1'b1, 21'h091E26, 3'd0, 1'b0, 1'b0);
        InValid = 1'b0; Flush = 1'b1; #1;
        chk("flush_inready", 64'(InReady), 64'd0);
        tick();
        chk("flush_valid", 64'(OutValid), 64'd0);
        chk("flush_ctrl", 64'(CtrlOut), 64'd0);
        Flush = 1'b0; #1;
        chk("post_flush_inready", 64'(InReady), 64'd1);
        tick();
        chk("post_flush_no_beat", 64'(OutValid), 64'd0);

        // illegal and FP-disabled decodes
        InValid = 1'b1; OpCode = 6'h3f;
        tick();
        exp_out("illegal_3f", 1'b1, 21'h0, 3'd0, 1'b1, 1'b1);
        OpCode = 6'h31;
        tick();
        exp_out("fld_s", 1'b1, 21'h090E26, 3'd0, 1'b1, 1'b0);
        exp_out0("fpen0_31", 1'b1, 21'h0, 3'd0, 1'b1, 1'b1);

        OpCode = 6'h11; fmt = 5'h08; ft = 5'h03;
        tick();
        exp_out("bc1t", 1'b1, 21'h0E8800, 3'd0, 1'b1, 1'b0);
        exp_out0("fpen0_bc1", 1'b1, 21'h0, 3'd0, 1'b1, 1'b1);
        ft = 5'h00;
        tick();
        exp_out("bc1f", 1'b1, 21'h0E4800, 3'd0, 1'b1, 1'b0);
        fmt = 5'h11;
        tick();
        exp_out("fp_d_arith", 1'b1, 21'h041401, 3'd0, 1'b1, 1'b0);
        fmt = 5'h05;
        tick();
        exp_out("fp_bad_fmt", 1'b1, 21'h0, 3'd0, 1'b1, 1'b1);
        OpCode = 6'h0f; fmt = 5'h00;
        tick();
        exp_out("lui", 1'b1, 21'h160A02, 3'd0, 1'b1, 1'b0);

        // double load: FP-disabled copy treats it as a single illegal op;
        // reset then lands mid-sequence on the enabled copy
        OpCode = 6'h35;
        tick();
        exp_out("rst_b0", 1'b1, 21'h091E26, 3'd0, 1'b0, 1'b0);
        exp_out0("fpen0_35", 1'b1, 21'h0, 3'd0, 1'b1, 1'b1);
        chk("fpen0_no_seq", 64'(InReady0), 64'd1);
        InValid = 1'b0; rst_n = 1'b0; #1;
        chk("rst_inready", 64'(InReady), 64'd0);
        tick();
        exp_out("mid_reset", 1'b0, 21'h0, 3'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick();
        chk("post_reset_no_beat", 64'(OutValid), 64'd0);
        chk("post_reset_inready", 64'(InReady), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
